// File: rtl/alu_exec_unit.sv
// MIPS execute stage: ALU control decode, WIDTH-bit ALU with registered result,
// and an iterative mult/div engine owning HI/LO. Divider built only with ALU_DIV_EN.
module alu_exec_unit #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = SHW + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   quo_q, quo_d, mcand_q, mcand_d;
    logic               neg_q, neg_d, negr_q, negr_d, div0_q, div0_d;
    logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d, lo_q, lo_d;
    logic               zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d, valid_q, valid_d;

    logic [WIDTH-1:0]   sum_add, sum_sub, abs_a, abs_b, alu_res;
    logic               ovf_add, ovf_sub, alu_ovf, alu_ill, go_mul, go_div, sgn;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign sum_add  = op_a + op_b;
    assign sum_sub  = op_a - op_b;
    assign ovf_add  = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_add[WIDTH-1] != op_a[WIDTH-1]);
    assign ovf_sub  = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sum_sub[WIDTH-1] != op_a[WIDTH-1]);
    assign abs_a    = op_a[WIDTH-1] ? -op_a : op_a;
    assign abs_b    = op_b[WIDTH-1] ? -op_b : op_b;
    assign sgn      = ~funct[0];
    // Shift-add on magnitudes; the sign is applied once when the product completes.
    assign mul_sum  = quo_q[0] ? (acc_q + {1'b0, mcand_q}) : acc_q;
    assign prod     = {acc_q[WIDTH-1:0], quo_q};
    assign prod_fix = neg_q ? -prod : prod;

`ifdef ALU_DIV_EN
    logic [WIDTH:0]     div_shift, div_diff;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign div_shift = {acc_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mcand_q};
    assign quo_fix   = neg_q ? -quo_q : quo_q;
    assign rem_fix   = negr_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
`endif

    always_comb begin
        state_d  = state_q;  cnt_d  = cnt_q;  acc_d = acc_q;  quo_d = quo_q;
        mcand_d  = mcand_q;  neg_d  = neg_q;  negr_d = negr_q; div0_d = div0_q;
        result_d = result_q; zero_d = zero_q; ovf_d = ovf_q;  ill_d = ill_q;
        hi_d     = hi_q;     lo_d   = lo_q;   valid_d = 1'b0;
        alu_res  = '0;  alu_ovf = 1'b0;  alu_ill = 1'b0;  go_mul = 1'b0;  go_div = 1'b0;
        case (state_q)
            S_IDLE: if (in_valid && !flush) begin
                case (aluop)
                    2'b00: alu_res = sum_add;
                    2'b01: alu_res = sum_sub;
                    2'b10: case (funct)
                        6'b100000: begin alu_res = sum_add; alu_ovf = ovf_add; end
                        6'b100001: alu_res = sum_add;
                        6'b100010: begin alu_res = sum_sub; alu_ovf = ovf_sub; end
                        6'b100011: alu_res = sum_sub;
                        6'b100100: alu_res = op_a & op_b;
                        6'b100101: alu_res = op_a | op_b;
                        6'b100110: alu_res = op_a ^ op_b;
                        6'b100111: alu_res = ~(op_a | op_b);
                        6'b101010: alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                        6'b101011: alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
                        6'b000000: alu_res = op_b << shamt;
                        6'b000010: alu_res = op_b >> shamt;
                        6'b000011: alu_res = $signed(op_b) >>> shamt;
                        6'b010000: alu_res = hi_q;
                        6'b010010: alu_res = lo_q;
                        6'b011000, 6'b011001: go_mul = 1'b1;
`ifdef ALU_DIV_EN
                        6'b011010, 6'b011011: go_div = 1'b1;
`endif
                        default: alu_ill = 1'b1;
                    endcase
                    default: alu_ill = 1'b1;
                endcase
                if (go_mul || go_div) begin
                    state_d = go_mul ? S_MUL : S_DIV;
                    cnt_d   = CW'(WIDTH);
                    acc_d   = '0;
                    neg_d   = sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    negr_d  = sgn & op_a[WIDTH-1];
                    div0_d  = (op_b == '0);
                    // Multiplier/dividend shifts through quo; multiplicand/divisor sits in mcand.
                    quo_d   = go_mul ? (sgn ? abs_b : op_b) : (sgn ? abs_a : op_a);
                    mcand_d = go_mul ? (sgn ? abs_a : op_a) : (sgn ? abs_b : op_b);
                end else begin
                    valid_d  = 1'b1;
                    result_d = alu_res;
                    zero_d   = !alu_ill && (alu_res == '0);
                    ovf_d    = alu_ovf;
                    ill_d    = alu_ill;
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;  valid_d = 1'b1;
                    {hi_d, lo_d} = prod_fix;
                    result_d = '0;  zero_d = 1'b0;  ovf_d = 1'b0;  ill_d = 1'b0;
                end else begin
                    acc_d = {1'b0, mul_sum[WIDTH:1]};
                    quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef ALU_DIV_EN
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;  valid_d = 1'b1;
                    lo_d = div0_q ? '1 : quo_fix;
                    hi_d = rem_fix;
                    result_d = '0;  zero_d = 1'b0;  ovf_d = 1'b0;  ill_d = 1'b0;
                end else begin
                    acc_d = div_diff[WIDTH] ? div_shift : div_diff;
                    quo_d = {quo_q[WIDTH-2:0], ~div_diff[WIDTH]};
                    cnt_d = cnt_q - CW'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;  cnt_q <= '0;  acc_q <= '0;  quo_q <= '0;  mcand_q <= '0;
            neg_q <= 1'b0;  negr_q <= 1'b0;  div0_q <= 1'b0;
            result_q <= '0;  zero_q <= 1'b0;  ovf_q <= 1'b0;  ill_q <= 1'b0;  valid_q <= 1'b0;
            hi_q <= '0;  lo_q <= '0;
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;  acc_q <= acc_d;  quo_q <= quo_d;  mcand_q <= mcand_d;
            neg_q <= neg_d;  negr_q <= negr_d;  div0_q <= div0_d;
            result_q <= result_d;  zero_q <= zero_d;  ovf_q <= ovf_d;  ill_q <= ill_d;  valid_q <= valid_d;
            hi_q <= hi_d;  lo_q <= lo_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (WIDTH=32); div expectations follow ALU_DIV_EN.
module tb_alu_exec_unit;
    localparam int W = 32;

    logic          clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0;
    logic [1:0]    aluop = '0;
    logic [5:0]    funct = '0;
    logic [4:0]    shamt = '0;
    logic [W-1:0]  op_a = '0, op_b = '0;
    logic          in_ready, out_valid, zero, overflow, illegal, busy;
    logic [W-1:0]  result, hi, lo;

    int checks = 0, errors = 0;
    int n, seen;
    bit ready_early;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct(funct), .shamt(shamt), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .result(result), .zero(zero), .overflow(overflow),
        .illegal(illegal), .busy(busy), .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        aluop = op; funct = fn; shamt = sh; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        $display("txn aluop=%b funct=%b shamt=%0d a=%h b=%h -> valid=%b result=%h ovf=%b ill=%b hi=%h lo=%h",
                 op, fn, sh, a, b, out_valid, result, overflow, illegal, hi, lo);
    endtask

    task automatic wait_done(output int cyc, output bit early);
        cyc = 0; early = 1'b0;
        while (cyc < 100) begin
            if (out_valid) break;
            if (in_ready) early = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hilo", {hi, lo}, 64'h0);
        chk("rst_result", {result, zero, overflow, illegal}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        send(2'b10, 6'b100000, 0, 32'h7FFFFFFF, 32'h1);
        chk("add_valid", out_valid, 1);
        chk("add_result", result, 32'h80000000);
        chk("add_ovf", overflow, 1);
        @(posedge clk); #1;
        chk("add_pulse_low", out_valid, 0);
        send(2'b10, 6'b100001, 0, 32'h7FFFFFFF, 32'h1);
        chk("addu", {result, overflow}, {32'h80000000, 1'b0});
        send(2'b00, 6'b000000, 0, 32'h7FFFFFFF, 32'h1);
        chk("aluop00", {result, overflow}, {32'h80000000, 1'b0});
        send(2'b01, 6'b000000, 0, 32'h5, 32'h5);
        chk("aluop01_zero", {result, zero, out_valid}, {32'h0, 1'b1, 1'b1});
        send(2'b10, 6'b100010, 0, 32'h80000000, 32'h1);
        chk("sub_ovf", {result, overflow}, {32'h7FFFFFFF, 1'b1});
        send(2'b10, 6'b101010, 0, 32'hFFFFFFFF, 32'h1);
        chk("slt", result, 1);
        send(2'b10, 6'b101011, 0, 32'hFFFFFFFF, 32'h1);
        chk("sltu", {result, zero}, {32'h0, 1'b1});
        send(2'b10, 6'b000011, 4, 32'h0, 32'h80000000);
        chk("sra", result, 32'hF8000000);
        send(2'b10, 6'b000010, 4, 32'h0, 32'h80000000);
        chk("srl", result, 32'h08000000);
        send(2'b10, 6'b000000, 31, 32'h0, 32'h3);
        chk("sll", result, 32'h80000000);
        send(2'b10, 6'b100100, 0, 32'hF0F0F0F0, 32'hFF00FF00);
        chk("and", result, 32'hF000F000);
        send(2'b10, 6'b100101, 0, 32'hF0F0F0F0, 32'hFF00FF00);
        chk("or_b2b_valid", {out_valid, result}, {1'b1, 32'hFFF0FFF0});
        send(2'b10, 6'b100110, 0, 32'hF0F0F0F0, 32'hFF00FF00);
        chk("xor", result, 32'h0FF00FF0);
        send(2'b10, 6'b100111, 0, 32'hF0F0F0F0, 32'hFF00FF00);
        chk("nor", result, 32'h000F000F);

        send(2'b10, 6'b011000, 0, 32'hFFFFFFFF, 32'h3);
        chk("mult_busy", {busy, in_ready, out_valid}, 3'b100);
        wait_done(n, ready_early);
        chk("mult_latency", n, 33);
        chk("mult_ready_low", ready_early, 0);
        chk("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        chk("mult_flags", {result, zero, overflow, illegal, in_ready}, {32'h0, 4'b0001});
        send(2'b10, 6'b010010, 0, 32'h0, 32'h0);
        chk("mflo", result, 32'hFFFFFFFD);
        send(2'b10, 6'b010000, 0, 32'h0, 32'h0);
        chk("mfhi", result, 32'hFFFFFFFF);

        send(2'b10, 6'b011001, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(n, ready_early);
        chk("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);

        send(2'b10, 6'b011001, 0, 32'h2, 32'h3);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_ready", {in_ready, busy, out_valid}, 3'b100);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
        chk("flush_no_valid", seen, 0);
        chk("flush_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
        flush = 1'b1;
        send(2'b00, 6'b000000, 0, 32'h1, 32'h1);
        flush = 1'b0;
        chk("flush_idle_drop", {out_valid, in_ready}, 2'b01);

`ifdef ALU_DIV_EN
        send(2'b10, 6'b011010, 0, 32'hFFFFFFF9, 32'h2);
        wait_done(n, ready_early);
        chk("div_latency", n, 33);
        chk("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        send(2'b10, 6'b011011, 0, 32'hA, 32'h0);
        wait_done(n, ready_early);
        chk("divu_by0", {hi, lo}, 64'h0000000A_FFFFFFFF);
        send(2'b10, 6'b011010, 0, 32'h80000000, 32'hFFFFFFFF);
        wait_done(n, ready_early);
        chk("div_minneg", {hi, lo}, 64'h00000000_80000000);
`else
        send(2'b10, 6'b011010, 0, 32'hFFFFFFF9, 32'h2);
        chk("div_illegal", {out_valid, illegal, result, in_ready}, {2'b11, 32'h0, 1'b1});
        chk("div_hilo_kept", {hi, lo}, 64'hFFFFFFFE_00000001);
`endif

        send(2'b10, 6'b111111, 0, 32'h1, 32'h1);
        chk("unk_funct", {out_valid, result, zero, illegal}, {1'b1, 32'h0, 2'b01});
        send(2'b11, 6'b100000, 0, 32'h1, 32'h1);
        chk("aluop11", {illegal, zero}, 2'b10);
        send(2'b10, 6'b100000, 0, 32'h2, 32'h3);
        chk("ill_cleared", {illegal, result}, {1'b0, 32'h5});

        send(2'b10, 6'b011001, 0, 32'h5, 32'h7);
        repeat (5) begin @(posedge clk); #1; end
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst_ready", {in_ready, busy, out_valid}, 3'b100);
        chk("midrst_hilo", {hi, lo}, 64'h0);
        chk("midrst_flags", {result, zero, overflow, illegal}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised MIPS execute-stage unit that merges ALU control decode (ALUop/funct) with a WIDTH-bit ALU.
- Adds a registered result with a valid/ready handshake.
- Adds an iterative multiply/divide engine that owns the HI/LO registers.
- Sits between register read and writeback. The control unit supplies ALUop; the instruction supplies funct/shamt.

Parameters:
- WIDTH, 32, datapath width; power of two, >= 8
- SHW, $clog2(WIDTH), shift-amount width (localparam-derived, not overridable)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- flush  in  1  abort in-flight mult/div; no output produced
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept; high only in IDLE
- aluop  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type via funct, 11 illegal
- funct  in  6  R-type function field
- shamt  in  SHW  shift amount for sll/srl/sra
- op_a  in  WIDTH  rs operand
- op_b  in  WIDTH  rt operand
- out_valid  out  1  one-cycle pulse, result/flags valid
- result  out  WIDTH  registered result
- zero  out  1  result == 0 (single-cycle ops only; 0 for mult/div)
- overflow  out  1  signed overflow on add/sub funct only
- illegal  out  1  unsupported aluop/funct
- busy  out  1  mult/div in progress
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async): state IDLE; in_ready=1; out_valid, result, zero, overflow, illegal, busy, hi, lo all 0.
- Accept: in_valid && in_ready at a rising edge. Inputs are captured; in_valid with in_ready low is ignored, not queued.
- Single-cycle ops: outputs are registered on the accepting edge, so out_valid pulses the following cycle. Back-to-back accepts give one result per cycle.
- R-type decode by funct:
  - add 100000, addu 100001, sub 100010, subu 100011
  - and 100100, or 100101, xor 100110, nor 100111
  - slt 101010 (signed), sltu 101011 (unsigned)
  - sll 000000 (op_b<<shamt), srl 000010 (logical), sra 000011 (arithmetic)
  - mfhi 010000 (result=hi), mflo 010010 (result=lo)
  - mult 011000, multu 011001, div 011010, divu 011011
- aluop 00/01: add/sub with overflow forced 0.
- Unknown funct or aluop 11: single-cycle; result=0, zero=0, illegal=1; hi/lo unchanged.
- Add/sub arithmetic: modulo 2^WIDTH. overflow=1 only for add/sub funct when signed overflow occurs; result is still written.
- State machine: IDLE -> MUL (mult/multu) or DIV (div/divu). A WIDTH-count step counter runs one shift-add or restoring-subtract step per cycle; counter reaching 0 returns to IDLE.
- Mult/div latency:
  - busy=1 and in_ready=0 from the cycle after accept.
  - out_valid pulses WIDTH+1 cycles after the accept edge, with hi/lo updated on the same edge.
  - result=0, zero=0, overflow=0, illegal=0 on that pulse.
  - in_ready returns to 1 in the out_valid cycle.
- mult/multu: {hi,lo} = 2*WIDTH-bit signed/unsigned product.
- div/divu: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend. Signed form divides magnitudes, then corrects signs.
- Divide by zero: lo = all ones, hi = op_a. No flag.
- Most-negative / -1: lo = most negative, hi = 0.
- flush: synchronous. In MUL/DIV it returns to IDLE next edge with no out_valid and hi/lo unchanged. In IDLE it drops the same-cycle accept.
- Reset mid-operation: immediate return to the reset values, including hi/lo.
- mfhi/mflo cannot be accepted while busy (in_ready low), so they always read the completed hi/lo.

Optional Feature:
- Macro: ALU_DIV_EN.
- Defined: div/divu handled as above.
- Undefined: div/divu decode as illegal (single-cycle, illegal=1, hi/lo unchanged); no divider logic synthesised.
- mult/multu are always present.

Test Plan:
- Reset mid-MUL (assert rst 5 cycles after accepting multu) -> all outputs 0 immediately, in_ready=1.
- Decode sweep, WIDTH=32:
  - aluop=10 add, 0x7FFFFFFF+1 -> result=0x80000000, overflow=1, out_valid 1 cycle later.
  - addu with the same operands -> overflow=0.
  - aluop=00 -> overflow=0.
  - slt(-1,1)=1 and sltu(-1,1)=0.
  - sra 0x80000000 by 4 -> 0xF8000000.
- mult 0xFFFFFFFF (-1) x 0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFD, out_valid 33 cycles after accept, in_ready low in between; then mflo returns 0xFFFFFFFD.
- With ALU_DIV_EN:
  - div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu 10/0 -> lo=0xFFFFFFFF, hi=10.
  - Without ALU_DIV_EN, div -> illegal=1, hi/lo unchanged.
- flush 10 cycles into mult -> no out_valid, hi/lo retain prior values, in_ready=1 next cycle.
- Unknown funct 111111 -> result=0, illegal=1; aluop=11 -> illegal=1; the next accepted add clears illegal.
